// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

    // One memory word: four byte lanes, lane 0 in bits [7:0].
    typedef logic [3:0][7:0] word_t;

    // Arbiter FSM states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Default number of cycles a transfer holds the memory port.
    localparam int MEM_LATENCY_DEFAULT = 4;

    // Port indices: instruction-side cache and data-side cache.
    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side request/response signals and memory-side signals.
// "slave" is the arbiter's view; "master" is the caches/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_arb_pkg::*;

    // Cache port 0 (instruction) and port 1 (data) requests
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    word_t             wdata0;
    word_t             wdata1;

    // Cache-side responses
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    word_t             rdata0;
    word_t             rdata1;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_data_in;
    logic              mem_write_en;
    word_t             mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
        output mem_addr, mem_data_in, mem_write_en,
        input  mem_data_out
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
        input  mem_addr, mem_data_in, mem_write_en,
        output mem_data_out
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the port that was
// not served last wins; a lone request wins outright.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_effreq,
    input  logic       i_last,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    // Pick a one-hot winner from the effective requests.
    always_comb begin
        o_grant = 2'b00;
        if (i_effreq == 2'b11) begin
            if (i_last) begin
                o_grant[PORT_I] = 1'b1;
            end else begin
                o_grant[PORT_D] = 1'b1;
            end
        end else begin
            o_grant = i_effreq;
        end
    end

    assign o_valid = |i_effreq;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port main-memory arbiter: serializes cache fills/write-backs, holds
// each transfer for MEM_LATENCY cycles and pulses done for one cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
    parameter int ADDR_W      = 32
)(
    input logic          clk,
    input logic          rst_b,
    mem_arbiter_if.slave bus
);

    localparam int                CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LATENCY);
    localparam logic [0:0]        ST_IDLE  = IDLE;
    localparam logic [0:0]        ST_BUSY  = BUSY;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;
    logic              r_port;
    logic              r_we;
    logic [1:0]        r_gnt;
    logic [1:0]        r_done;
    word_t             r_rdata0;
    word_t             r_rdata1;
    logic [ADDR_W-1:0] r_mem_addr;
    word_t             r_mem_data_in;
    logic              r_mem_write_en;

    logic [1:0]        w_effreq;
    logic [1:0]        w_grant;
    logic              w_valid;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    word_t             w_sel_wdata;

    // A port that just completed is masked for one cycle so it cannot be
    // regranted in its own done cycle.
    assign w_effreq[PORT_I] = bus.req0 & ~r_done[PORT_I];
    assign w_effreq[PORT_D] = bus.req1 & ~r_done[PORT_D];

    rr_arb2 u_rr_arb2 (
        .i_effreq (w_effreq),
        .i_last   (r_last),
        .o_grant  (w_grant),
        .o_valid  (w_valid)
    );

    // Route the winning port's request fields toward the memory latches.
    always_comb begin
        w_sel_we    = bus.we0;
        w_sel_addr  = bus.addr0;
        w_sel_wdata = bus.wdata0;
        if (w_grant[PORT_D]) begin
            w_sel_we    = bus.we1;
            w_sel_addr  = bus.addr1;
            w_sel_wdata = bus.wdata1;
        end else begin
            w_sel_we    = bus.we0;
            w_sel_addr  = bus.addr0;
            w_sel_wdata = bus.wdata0;
        end
    end

    // Arbitration FSM, latency counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state        <= ST_IDLE;
            r_cnt          <= CNT_ZERO;
            r_last         <= 1'b1;
            r_port         <= 1'b0;
            r_we           <= 1'b0;
            r_gnt          <= 2'b00;
            r_done         <= 2'b00;
            r_rdata0       <= '0;
            r_rdata1       <= '0;
            r_mem_addr     <= '0;
            r_mem_data_in  <= '0;
            r_mem_write_en <= 1'b0;
        end else begin
            // done and write strobe are single-cycle unless set below
            r_done         <= 2'b00;
            r_mem_write_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state        <= ST_BUSY;
                        r_cnt          <= CNT_ONE;
                        r_port         <= w_grant[PORT_D];
                        r_last         <= w_grant[PORT_D];
                        r_we           <= w_sel_we;
                        r_mem_write_en <= w_sel_we;
                        r_mem_addr     <= {w_sel_addr[ADDR_W-1:2], 2'b00};
                        r_mem_data_in  <= w_sel_wdata;
                        r_gnt          <= w_grant;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_gnt   <= 2'b00;
                        if (r_port) begin
                            r_done <= 2'b10;
                        end else begin
                            r_done <= 2'b01;
                        end
                        if (!r_we && r_port) begin
                            r_rdata1 <= bus.mem_data_out;
                        end else if (!r_we) begin
                            r_rdata0 <= bus.mem_data_out;
                        end else begin
                            r_rdata0 <= r_rdata0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign bus.gnt0         = r_gnt[PORT_I];
    assign bus.gnt1         = r_gnt[PORT_D];
    assign bus.done0        = r_done[PORT_I];
    assign bus.done1        = r_done[PORT_D];
    assign bus.rdata0       = r_rdata0;
    assign bus.rdata1       = r_rdata1;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_data_in  = r_mem_data_in;
    assign bus.mem_write_en = r_mem_write_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected transfers into a
// scoreboard queue; a negedge monitor checks every grant/done cycle.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        word_t       wdata;
        word_t       rdata;
        int          done_cyc;
    } txn_t;

    logic  clk;
    logic  rst_b;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    gcnt = 0;
    int    flush_req = 0;
    int    flush_ack = 0;
    bit    mon_en = 1'b0;
    txn_t  sbq[$];
    word_t exp_rdata [2];

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.MEM_LATENCY(4), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents seen by the arbiter, keyed by word address.
    function automatic word_t mem_model(logic [31:0] a);
        case (a)
            32'h0000_1238: mem_model = 32'hDDCC_BBAA;
            32'h0000_2000: mem_model = 32'h0F0E_0D0C;
            32'h0000_3000: mem_model = 32'hA5A5_5A5A;
            default:       mem_model = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.mem_data_out = mem_model(bus.mem_addr);

    task automatic chk1(string nm, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chkw(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    // Queue one expected transfer; rd is the hand-computed read word.
    task automatic expect_txn(bit port, bit we, logic [31:0] addr, word_t wd,
                              word_t rd, int done_cyc);
        txn_t t;
        t.port     = port;
        t.we       = we;
        t.addr     = addr;
        t.wdata    = wd;
        t.done_cyc = done_cyc;
        if (we) begin
            t.rdata = exp_rdata[port];
        end else begin
            t.rdata         = rd;
            exp_rdata[port] = rd;
        end
        sbq.push_back(t);
    endtask

    task automatic do_reset();
        rst_b        = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        tick();
        rst_b = 1'b0;
        flush_req++;
    endtask

    // Monitor: reset-state checks, invariants, per-grant-cycle and done checks.
    always @(negedge clk) begin
        txn_t t;
        if (mon_en) begin
            if (flush_req != flush_ack) begin
                chk1("rst_gnt0", bus.gnt0, 1'b0);
                chk1("rst_gnt1", bus.gnt1, 1'b0);
                chk1("rst_done0", bus.done0, 1'b0);
                chk1("rst_done1", bus.done1, 1'b0);
                chk1("rst_mem_we", bus.mem_write_en, 1'b0);
                chkw("rst_mem_addr", bus.mem_addr, 32'h0);
                chkw("rst_mem_data_in", bus.mem_data_in, 32'h0);
                chkw("rst_rdata0", bus.rdata0, 32'h0);
                chkw("rst_rdata1", bus.rdata1, 32'h0);
                sbq.delete();
                gcnt = 0;
                flush_ack = flush_req;
            end else begin
                chk1("one_gnt", bus.gnt0 & bus.gnt1, 1'b0);
                chk1("one_done", bus.done0 & bus.done1, 1'b0);
                chk1("gnt_done0", bus.gnt0 & bus.done0, 1'b0);
                chk1("gnt_done1", bus.gnt1 & bus.done1, 1'b0);
                if (bus.gnt0 || bus.gnt1) begin
                    if (sbq.size() == 0) begin
                        chk1("spurious_gnt", 1'b1, 1'b0);
                    end else begin
                        chk1("gnt_port", bus.gnt1, sbq[0].port);
                        chkw("mem_addr", bus.mem_addr, sbq[0].addr);
                        if (sbq[0].we) chkw("mem_data_in", bus.mem_data_in, sbq[0].wdata);
                        chk1("mem_write_en", bus.mem_write_en, sbq[0].we && (gcnt == 0));
                        gcnt++;
                    end
                end else begin
                    chk1("mem_we_idle", bus.mem_write_en, 1'b0);
                end
                if (bus.done0 || bus.done1) begin
                    if (sbq.size() == 0) begin
                        chk1("spurious_done", 1'b1, 1'b0);
                    end else begin
                        t = sbq.pop_front();
                        chk1("done_port", bus.done1, t.port);
                        chkw("done_cycle", cyc, t.done_cyc);
                        chkw("gnt_cycles", gcnt, 32'd4);
                        chkw("rdata", t.port ? bus.rdata1 : bus.rdata0, t.rdata);
                        gcnt = 0;
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int b;
        int d;
        rst_b      = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = 32'h0;
        bus.addr1  = 32'h0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        flush_req++;
        mon_en = 1'b1;
        tick();

        // Single read on port 1
        b = cyc;
        bus.we1 = 1'b0; bus.addr1 = 32'h0000_1238; bus.req1 = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0000_1238, '0, 32'hDDCC_BBAA, b + 5);
        wait_until(b + 5); bus.req1 = 1'b0;
        wait_until(b + 7);

        // Single write on port 0; rdata0 stays 0
        b = cyc;
        bus.we0 = 1'b1; bus.addr0 = 32'h0000_0040; bus.wdata0 = 32'h1122_3344; bus.req0 = 1'b1;
        expect_txn(1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, '0, b + 5);
        wait_until(b + 5); bus.req0 = 1'b0;
        wait_until(b + 7);

        // Contention right after reset (last = 1): 0, then 1, then 0 again
        do_reset();
        tick();
        b = cyc;
        bus.we0 = 1'b0; bus.addr0 = 32'h0000_3000; bus.req0 = 1'b1;
        bus.we1 = 1'b0; bus.addr1 = 32'h0000_2000; bus.req1 = 1'b1;
        expect_txn(1'b0, 1'b0, 32'h0000_3000, '0, 32'hA5A5_5A5A, b + 5);
        expect_txn(1'b1, 1'b0, 32'h0000_2000, '0, 32'h0F0E_0D0C, b + 10);
        expect_txn(1'b0, 1'b0, 32'h0000_3000, '0, 32'hA5A5_5A5A, b + 15);
        wait_until(b + 11); bus.req1 = 1'b0;
        wait_until(b + 15); bus.req0 = 1'b0;
        wait_until(b + 17);

        // Tie with last = 0: port 1 first, then a write on port 0
        b = cyc;
        bus.we0 = 1'b1; bus.addr0 = 32'h0000_0044; bus.wdata0 = 32'h5566_7788; bus.req0 = 1'b1;
        bus.we1 = 1'b0; bus.addr1 = 32'h0000_1238; bus.req1 = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0000_1238, '0, 32'hDDCC_BBAA, b + 5);
        expect_txn(1'b0, 1'b1, 32'h0000_0044, 32'h5566_7788, '0, b + 10);
        wait_until(b + 5); bus.req1 = 1'b0;
        wait_until(b + 10); bus.req0 = 1'b0;
        wait_until(b + 12);

        // Done masking: req0 held through done, regrant only at next IDLE
        b = cyc;
        bus.we0 = 1'b0; bus.addr0 = 32'h0000_3000; bus.req0 = 1'b1;
        expect_txn(1'b0, 1'b0, 32'h0000_3000, '0, 32'hA5A5_5A5A, b + 5);
        expect_txn(1'b0, 1'b0, 32'h0000_3000, '0, 32'hA5A5_5A5A, b + 11);
        wait_until(b + 11); bus.req0 = 1'b0;
        wait_until(b + 13);

        // Reset during BUSY cycle 2 of a write, then a fresh read on port 1
        b = cyc;
        bus.we0 = 1'b1; bus.addr0 = 32'h0000_0080; bus.wdata0 = 32'hCAFE_F00D; bus.req0 = 1'b1;
        expect_txn(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, '0, b + 5);
        wait_until(b + 2);
        bus.req0 = 1'b0;
        do_reset();
        tick();
        d = cyc;
        bus.we1 = 1'b0; bus.addr1 = 32'h0000_1238; bus.req1 = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0000_1238, '0, 32'hDDCC_BBAA, d + 5);
        wait_until(d + 5); bus.req1 = 1'b0;
        wait_until(d + 7);

        // Request dropped and address changed mid-transfer; low bits forced 00
        b = cyc;
        bus.we1 = 1'b0; bus.addr1 = 32'h0000_2003; bus.req1 = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0000_2000, '0, 32'h0F0E_0D0C, b + 5);
        wait_until(b + 2);
        bus.req1 = 1'b0; bus.addr1 = 32'h5555_0000;
        wait_until(b + 7);

        for (int i = 0; i < 50 && sbq.size() != 0; i++) tick();
        chkw("queue_drained", sbq.size(), 32'd0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-side cache (port 0) and the data-side cache (port 1).
- Serializes block transfers, holding each one for the fixed memory latency, then returns read data with a one-cycle done pulse.
- Round-robin on contention, so neither cache starves.
- Sits between both cache miss/write-back interfaces and the memory model; memory-side signals match the caches' memory interface.

Parameters:
- MEM_LATENCY, 4: cycles address and write data are held on memory per transaction; read data is valid in the last held cycle.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_b  in  1  synchronous, active-high reset (1 = reset), sampled on the rising clk edge
- req0 / req1  in  1  transaction request from port 0 / port 1; held high until that port's done pulse
- we0 / we1  in  1  1 = write-back, 0 = fill read
- addr0 / addr1  in  ADDR_W  word address (bits [1:0] ignored, forced to 00 on output)
- wdata0 / wdata1  in  8 x [0:3]  write word, byte lanes 0..3
- gnt0 / gnt1  out  1  high while that port's transaction owns memory
- done0 / done1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  8 x [0:3]  read word, valid from the done cycle until the next completion on that port
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  8 x [0:3]  memory write data
- mem_write_en  out  1  memory write strobe
- mem_data_out  in  8 x [0:3]  memory read data

Behaviour:
- Reset values: state IDLE, count 0, last = 1. All outputs 0: mem_addr, mem_data_in, mem_write_en, gnt*, done*, rdata*.
- Reset mid-transaction: abandon the transfer and return to IDLE next cycle. No done pulse; mem_write_en low.
- IDLE:
  - Form the effective requests: effreq_x = req_x & ~done_x. This masks the port just served.
  - If only one effreq is high, grant it.
  - If both are high, grant the port != last.
  - At the edge: latch the winner's we/addr/wdata into mem_write_en/mem_addr/mem_data_in. Set gnt_x = 1, last = x, count = 1, state BUSY.
- BUSY:
  - Hold mem_addr and mem_data_in stable for MEM_LATENCY cycles (count 1..MEM_LATENCY).
  - mem_write_en is high only in cycle count == 1 of a write. It is low for all reads and for write cycles 2..L.
  - At the edge ending cycle count == MEM_LATENCY:
    - if read, rdata_x <= mem_data_out; if write, rdata_x is unchanged;
    - done_x <= 1, gnt_x <= 0, state IDLE.
  - Otherwise count <= count + 1.
- Done cycle: state is IDLE, so the other port can be granted in the same cycle. Per-transaction occupancy is MEM_LATENCY + 1 cycles.
- Latency: req_x sampled in IDLE at cycle t gives gnt_x in cycles t+1..t+L and done_x in cycle t+L+1.
- Request dropped while granted: the transfer still completes and done still pulses.
- req or address changes during BUSY are ignored; the latched copy is used.
- Request arriving during BUSY: waits and is arbitrated in the next IDLE cycle.
- Invariants:
  - at most one gnt high;
  - at most one done high;
  - gnt and done are never high together on one port.
- Count width is clog2(MEM_LATENCY+1). MEM_LATENCY >= 1; a value of 1 means write-enable and completion occur in the same BUSY cycle.

Decomposition:
- Package mem_arb_pkg:
  - typedef word_t (array of four 8-bit lanes);
  - enum state_t {IDLE, BUSY};
  - localparam default MEM_LATENCY = 4;
  - port index constants PORT_I = 0, PORT_D = 1.
- Sub-module rr_arb2:
  - combinational 2-way round-robin;
  - inputs: effreq[1:0], last;
  - outputs: one-hot grant[1:0], valid.
- The top level holds the FSM, counter and datapath latches.

Test Plan:
- Single read: reset, mem_data_out = {8'hDD,8'hCC,8'hBB,8'hAA}, req1 = 1, we1 = 0, addr1 = 32'h0000_1238 at cycle 0. Expect:
  - gnt1 high in cycles 1-4 with mem_addr = 32'h1238;
  - mem_write_en low throughout;
  - done1 in cycle 5 with rdata1 lanes = AA, BB, CC, DD.
- Single write: req0 = 1, we0 = 1, addr0 = 32'h40, wdata0 = {11,22,33,44}. Expect:
  - mem_write_en = 1 only in cycle 1;
  - mem_data_in = wdata0 in cycles 1-4;
  - done0 in cycle 5;
  - rdata0 unchanged.
- Contention: req0 = req1 = 1 from cycle 0 after reset (last = 1). Expect:
  - port 0 granted cycles 1-4, done0 in cycle 5;
  - port 1 granted cycles 6-9, done1 in cycle 10;
  - with both still requesting, port 0 granted next at cycle 11.
- Done masking: req0 held high through the done0 cycle, req1 = 0. Expect no regrant of port 0 in the done cycle; regrant at the following IDLE only if req0 is still 1.
- Reset mid-op: assert rst_b = 1 in BUSY cycle 2 of a write. Expect next cycle:
  - all outputs 0 and state IDLE;
  - no done pulse;
  - a new req1 after reset is served with full MEM_LATENCY timing.
- Req drop / address change: deassert req1 and change addr1 in BUSY cycle 2. Expect mem_addr to hold the latched value and done1 still to pulse in cycle 5.
